// File: rtl/ibex_rf_wr_sched.sv
// Register-file write-port scheduler: merges writeback results, load responses
// and an auxiliary valid/ready source onto the single RF write port.
module ibex_rf_wr_sched #(
  parameter int unsigned StarveLimit = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_waddr_i,
  input  logic [31:0] wb_wdata_i,
  input  logic        lsu_we_i,
  input  logic [4:0]  lsu_waddr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        aux_valid_i,
  output logic        aux_ready_o,
  input  logic [4:0]  aux_waddr_i,
  input  logic [31:0] aux_wdata_i,
  output logic        stall_o,
  output logic [31:0] rf_wr_pending_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic [1:0]  rf_src_o
);

  typedef enum logic [1:0] {
    SrcWb   = 2'd0,
    SrcLsu  = 2'd1,
    SrcAux  = 2'd2,
    SrcNone = 2'd3
  } src_e;

  // Starvation timer counts down from the limit; reaching zero means starved.
  localparam logic [3:0] StarveInit = 4'(StarveLimit);

  logic [1:0]  count, count_next;
  logic [4:0]  buf_addr      [2];
  logic [31:0] buf_data      [2];
  logic [4:0]  buf_addr_next [2];
  logic [31:0] buf_data_next [2];
  logic        push_slot;
  logic [3:0]  starve_left, starve_left_next;
  logic        starve;
  logic        push, pop;
  src_e        src;

  assign starve   = (starve_left == 4'd0);
  assign stall_o  = (count != 2'd0) | starve;
  assign rf_src_o = src;

  always_comb begin
    rf_wr_pending_o = '0;
    if (count != 2'd0) rf_wr_pending_o[buf_addr[0]] = 1'b1;
    if (count == 2'd2) rf_wr_pending_o[buf_addr[1]] = 1'b1;
  end

  always_comb begin
    rf_we_o     = 1'b0;
    rf_waddr_o  = '0;
    rf_wdata_o  = '0;
    src         = SrcNone;
    aux_ready_o = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    if (wb_we_i) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = wb_waddr_i;
      rf_wdata_o = wb_wdata_i;
      src        = SrcWb;
      push       = lsu_we_i;
    end else if (starve && aux_valid_i && (count != 2'd2)) begin
      rf_we_o     = 1'b1;
      rf_waddr_o  = aux_waddr_i;
      rf_wdata_o  = aux_wdata_i;
      src         = SrcAux;
      aux_ready_o = 1'b1;
      push        = lsu_we_i;
    end else if (count != 2'd0) begin
      // A live load queues behind the head so loads retire in arrival order.
      rf_we_o    = 1'b1;
      rf_waddr_o = buf_addr[0];
      rf_wdata_o = buf_data[0];
      src        = SrcLsu;
      pop        = 1'b1;
      push       = lsu_we_i;
    end else if (lsu_we_i) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = lsu_waddr_i;
      rf_wdata_o = lsu_wdata_i;
      src        = SrcLsu;
    end else if (aux_valid_i) begin
      rf_we_o     = 1'b1;
      rf_waddr_o  = aux_waddr_i;
      rf_wdata_o  = aux_wdata_i;
      src         = SrcAux;
      aux_ready_o = 1'b1;
    end
  end

  // Entry 0 is always the head; a pop shifts entry 1 down.
  assign push_slot = pop ? (count == 2'd2) : (count == 2'd1);

  always_comb begin
    buf_addr_next = buf_addr;
    buf_data_next = buf_data;
    count_next    = count;
    if (pop) begin
      buf_addr_next[0] = buf_addr[1];
      buf_data_next[0] = buf_data[1];
      count_next       = count - 2'd1;
    end
    if (push) begin
      buf_addr_next[push_slot] = lsu_waddr_i;
      buf_data_next[push_slot] = lsu_wdata_i;
      count_next               = count_next + 2'd1;
    end
  end

  always_comb begin
    starve_left_next = starve_left;
    if (!aux_valid_i || aux_ready_o) begin
      starve_left_next = StarveInit;
    end else if (!starve) begin
      starve_left_next = starve_left - 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count       <= 2'd0;
      buf_addr    <= '{default: '0};
      buf_data    <= '{default: '0};
      starve_left <= StarveInit;
    end else begin
      count       <= count_next;
      buf_addr    <= buf_addr_next;
      buf_data    <= buf_data_next;
      starve_left <= starve_left_next;
    end
  end

  // The writeback stage must honour stall; overflow is only reachable if it does not.
  wb_honours_stall: assert property (@(posedge clk_i) disable iff (rst_i)
    !(stall_o && wb_we_i));

  no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && (count == 2'd2)));

  count_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
    count != 2'd3);

endmodule

// File: tb/tb_ibex_rf_wr_sched.sv
// Bench for ibex_rf_wr_sched: directed vector table, reset-mid-burst sequence,
// then random traffic checked against a queue-based model of the grant rules.
module tb_ibex_rf_wr_sched;
  localparam int LIMIT = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wb_we_i;
  logic [4:0]  wb_waddr_i;
  logic [31:0] wb_wdata_i;
  logic        lsu_we_i;
  logic [4:0]  lsu_waddr_i;
  logic [31:0] lsu_wdata_i;
  logic        aux_valid_i;
  logic        aux_ready_o;
  logic [4:0]  aux_waddr_i;
  logic [31:0] aux_wdata_i;
  logic        stall_o;
  logic [31:0] rf_wr_pending_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [1:0]  rf_src_o;

  ibex_rf_wr_sched #(.StarveLimit(LIMIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .lsu_we_i(lsu_we_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .aux_valid_i(aux_valid_i), .aux_ready_o(aux_ready_o),
    .aux_waddr_i(aux_waddr_i), .aux_wdata_i(aux_wdata_i),
    .stall_o(stall_o), .rf_wr_pending_o(rf_wr_pending_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .rf_src_o(rf_src_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf_shadow [32];
  always @(posedge clk_i) begin
    if (!rst_i && rf_we_o) rf_shadow[rf_waddr_o] <= rf_wdata_o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wbw, input logic [4:0] wba, input logic [31:0] wbd,
                       input logic lw, input logic [4:0] la, input logic [31:0] ld,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad);
    wb_we_i = wbw;  wb_waddr_i = wba;  wb_wdata_i = wbd;
    lsu_we_i = lw;  lsu_waddr_i = la;  lsu_wdata_i = ld;
    aux_valid_i = av; aux_waddr_i = aa; aux_wdata_i = ad;
  endtask

  typedef struct {
    logic wbw; logic [4:0] wba; logic [31:0] wbd;
    logic lw;  logic [4:0] la;  logic [31:0] ld;
    logic av;  logic [4:0] aa;  logic [31:0] ad;
    logic e_we; logic [4:0] e_a; logic [31:0] e_d; logic [1:0] e_src;
    logic e_rdy; logic e_stall; logic [31:0] e_pend;
  } vec_t;

  function automatic vec_t v(
      input logic wbw, input logic [4:0] wba, input logic [31:0] wbd,
      input logic lw, input logic [4:0] la, input logic [31:0] ld,
      input logic av, input logic [4:0] aa, input logic [31:0] ad,
      input logic e_we, input logic [4:0] e_a, input logic [31:0] e_d,
      input logic [1:0] e_src, input logic e_rdy, input logic e_stall,
      input logic [31:0] e_pend);
    vec_t r;
    r.wbw = wbw; r.wba = wba; r.wbd = wbd;
    r.lw = lw; r.la = la; r.ld = ld;
    r.av = av; r.aa = aa; r.ad = ad;
    r.e_we = e_we; r.e_a = e_a; r.e_d = e_d; r.e_src = e_src;
    r.e_rdy = e_rdy; r.e_stall = e_stall; r.e_pend = e_pend;
    return r;
  endfunction

  // Reference model: load queue plus a count of consecutive ungranted aux cycles.
  typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t lq[$];
  int   wait_cycles;

  task automatic mstep(input string tag,
                       input logic wbw, input logic [4:0] wba, input logic [31:0] wbd,
                       input logic lw, input logic [4:0] la, input logic [31:0] ld,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       output logic granted);
    logic e_we; logic [4:0] e_a; logic [31:0] e_d; logic [1:0] e_src;
    logic e_stall; logic [31:0] e_pend;
    bit   starved, do_push, do_pop;
    ent_t ne;
    @(negedge clk_i);
    drive(wbw, wba, wbd, lw, la, ld, av, aa, ad);
    #1;
    starved = (wait_cycles >= LIMIT);
    e_stall = (lq.size() != 0) || starved;
    e_pend  = '0;
    foreach (lq[k]) e_pend[lq[k].a] = 1'b1;
    e_we = 1'b1; e_a = '0; e_d = '0; e_src = 2'd3;
    granted = 1'b0; do_push = 1'b0; do_pop = 1'b0;
    if (wbw) begin
      e_a = wba; e_d = wbd; e_src = 2'd0; do_push = lw;
    end else if (starved && av && lq.size() <= 1) begin
      e_a = aa; e_d = ad; e_src = 2'd2; granted = 1'b1; do_push = lw;
    end else if (lq.size() > 0) begin
      e_a = lq[0].a; e_d = lq[0].d; e_src = 2'd1; do_pop = 1'b1; do_push = lw;
    end else if (lw) begin
      e_a = la; e_d = ld; e_src = 2'd1;
    end else if (av) begin
      e_a = aa; e_d = ad; e_src = 2'd2; granted = 1'b1;
    end else begin
      e_we = 1'b0;
    end
    chk({tag, "_we"}, 32'(rf_we_o), 32'(e_we));
    chk({tag, "_src"}, 32'(rf_src_o), 32'(e_src));
    chk({tag, "_ready"}, 32'(aux_ready_o), 32'(granted));
    chk({tag, "_stall"}, 32'(stall_o), 32'(e_stall));
    chk({tag, "_pend"}, rf_wr_pending_o, e_pend);
    if (e_we) begin
      chk({tag, "_addr"}, 32'(rf_waddr_o), 32'(e_a));
      chk({tag, "_data"}, rf_wdata_o, e_d);
    end
    @(posedge clk_i);
    if (do_pop) void'(lq.pop_front());
    if (do_push) begin
      ne.a = la; ne.d = ld;
      lq.push_back(ne);
    end
    if (av && !granted) wait_cycles = (wait_cycles >= LIMIT) ? LIMIT : wait_cycles + 1;
    else wait_cycles = 0;
  endtask

  vec_t tbl[$];

  initial begin
    logic        g;
    logic        hold_v;
    logic [4:0]  hold_a;
    logic [31:0] hold_d;
    logic        wbw, lw;
    bit          m_stall;
    vec_t        t;
    string       tag;

    // idle
    tbl.push_back(v(0,0,0,        0,0,0,         0,0,0,        0,0,0,        3,0,0,0));
    // collision, then a streaming load to the same register
    tbl.push_back(v(1,5,'h11,     1,6,'h22,      0,0,0,        1,5,'h11,     0,0,0,0));
    tbl.push_back(v(0,0,0,        1,6,'h33,      0,0,0,        1,6,'h22,     1,0,1,'h40));
    tbl.push_back(v(0,0,0,        0,0,0,         0,0,0,        1,6,'h33,     1,0,1,'h40));
    tbl.push_back(v(0,0,0,        0,0,0,         0,0,0,        0,0,0,        3,0,0,0));
    // idle aux grant
    tbl.push_back(v(0,0,0,        0,0,0,         1,7,'h77,     1,7,'h77,     2,1,0,0));
    // aux starved by writeback for LIMIT cycles, then forced through
    for (int k = 0; k < LIMIT; k++)
      tbl.push_back(v(1,5'(k+1),32'h100+k, 0,0,0, 1,9,'h99, 1,5'(k+1),32'h100+k, 0,0,0,0));
    tbl.push_back(v(0,0,0,        0,0,0,         1,9,'h99,     1,9,'h99,     2,1,1,0));
    tbl.push_back(v(0,0,0,        0,0,0,         0,0,0,        0,0,0,        3,0,0,0));
    // forced aux grant with count 1 plus a live load fills the FIFO
    tbl.push_back(v(1,1,'h100,    1,10,'hA0,     1,12,'hCC,    1,1,'h100,    0,0,0,0));
    tbl.push_back(v(0,0,0,        1,11,'hA1,     1,12,'hCC,    1,10,'hA0,    1,0,1,'h400));
    tbl.push_back(v(0,0,0,        1,13,'hA2,     1,12,'hCC,    1,11,'hA1,    1,0,1,'h800));
    tbl.push_back(v(0,0,0,        1,14,'hA3,     1,12,'hCC,    1,13,'hA2,    1,0,1,'h2000));
    tbl.push_back(v(0,0,0,        1,15,'hA4,     1,12,'hCC,    1,12,'hCC,    2,1,1,'h4000));
    // count 2 with loads streaming: starve reached but blocked until count drops
    tbl.push_back(v(0,0,0,        1,17,'hA5,     1,16,'hDD,    1,14,'hA3,    1,0,1,'hC000));
    tbl.push_back(v(0,0,0,        1,18,'hA6,     1,16,'hDD,    1,15,'hA4,    1,0,1,'h28000));
    tbl.push_back(v(0,0,0,        1,19,'hA7,     1,16,'hDD,    1,17,'hA5,    1,0,1,'h60000));
    tbl.push_back(v(0,0,0,        1,20,'hA8,     1,16,'hDD,    1,18,'hA6,    1,0,1,'hC0000));
    tbl.push_back(v(0,0,0,        1,21,'hA9,     1,16,'hDD,    1,19,'hA7,    1,0,1,'h180000));
    tbl.push_back(v(0,0,0,        0,0,0,         1,16,'hDD,    1,20,'hA8,    1,0,1,'h300000));
    tbl.push_back(v(0,0,0,        0,0,0,         1,16,'hDD,    1,16,'hDD,    2,1,1,'h200000));
    tbl.push_back(v(0,0,0,        0,0,0,         0,0,0,        1,21,'hA9,    1,0,1,'h200000));
    tbl.push_back(v(0,0,0,        0,0,0,         0,0,0,        0,0,0,        3,0,0,0));

    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_pend", rf_wr_pending_o, 0);
    chk("rst_we", 32'(rf_we_o), 0);
    chk("rst_ready", 32'(aux_ready_o), 0);
    chk("rst_src", 32'(rf_src_o), 3);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      @(negedge clk_i);
      drive(t.wbw, t.wba, t.wbd, t.lw, t.la, t.ld, t.av, t.aa, t.ad);
      #1;
      tag = $sformatf("vec%0d", i);
      chk({tag, "_we"}, 32'(rf_we_o), 32'(t.e_we));
      chk({tag, "_src"}, 32'(rf_src_o), 32'(t.e_src));
      chk({tag, "_ready"}, 32'(aux_ready_o), 32'(t.e_rdy));
      chk({tag, "_stall"}, 32'(stall_o), 32'(t.e_stall));
      chk({tag, "_pend"}, rf_wr_pending_o, t.e_pend);
      if (t.e_we) begin
        chk({tag, "_addr"}, 32'(rf_waddr_o), 32'(t.e_a));
        chk({tag, "_data"}, rf_wdata_o, t.e_d);
      end
    end
    @(negedge clk_i);
    chk("x6_final", rf_shadow[6], 'h33);
    chk("x16_final", rf_shadow[16], 'hDD);
    chk("x21_final", rf_shadow[21], 'hA9);

    // Reset while the FIFO holds two loads.
    lq.delete();
    wait_cycles = 0;
    mstep("rs0", 1, 3, 'h300, 1, 4, 'h40, 1, 8, 'h80, g);
    for (int k = 0; k < LIMIT; k++)
      mstep($sformatf("rs%0d", k + 1), 0, 0, 0, 1, 5'(20 + k), 32'h50 + k, 1, 8, 'h80, g);
    chk("rs_full_model", 32'(lq.size()), 2);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rs_full_pend", 32'(rf_wr_pending_o != 0), 1);
    rst_i = 1'b1;
    #1;
    chk("rs_stall", 32'(stall_o), 0);
    chk("rs_pend", rf_wr_pending_o, 0);
    chk("rs_we", 32'(rf_we_o), 0);
    chk("rs_src", 32'(rf_src_o), 3);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    lq.delete();
    wait_cycles = 0;
    mstep("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, g);

    // Random traffic that honours the stall contract and aux hold rule.
    hold_v = 1'b0; hold_a = '0; hold_d = '0;
    for (int n = 0; n < 3000; n++) begin
      m_stall = (lq.size() != 0) || (wait_cycles >= LIMIT);
      wbw = !m_stall && ($urandom_range(0, 99) < 65);
      lw  = ($urandom_range(0, 99) < 40);
      if (!hold_v && ($urandom_range(0, 2) == 0)) begin
        hold_v = 1'b1;
        hold_a = 5'($urandom);
        hold_d = $urandom;
      end
      mstep($sformatf("rnd%0d", n), wbw, 5'($urandom), $urandom,
            lw, 5'($urandom), $urandom, hold_v, hold_a, hold_d, g);
      if (g) hold_v = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ibex_rf_wr_sched.md
# ibex_rf_wr_sched

Scheduler for the single register-file write port. It merges three write sources onto one port:
- ID/EX-writeback results (highest priority, never back-pressured).
- LSU load responses (never back-pressured, buffered on collision).
- An auxiliary valid/ready source such as debug or a coprocessor (lowest priority, starvation-guarded).

It sits between the writeback stage/LSU and the register file, and stalls ID/EX while buffered load data drains.

## Interface
Parameters:
- StarveLimit, 4: consecutive un-granted cycles of `aux_valid_i` before aux is forced through; legal range 1..15.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- wb_we_i  in  1  writeback result write request
- wb_waddr_i  in  5  writeback destination
- wb_wdata_i  in  32  writeback data
- lsu_we_i  in  1  load response write; must be accepted this cycle
- lsu_waddr_i  in  5  load destination
- lsu_wdata_i  in  32  load data
- aux_valid_i  in  1  aux write request; held with stable addr/data until accepted
- aux_ready_o  out  1  aux write accepted this cycle
- aux_waddr_i  in  5  aux destination
- aux_wdata_i  in  32  aux data
- stall_o  out  1  ID/EX must not assert `wb_we_i` in this cycle
- rf_wr_pending_o  out  32  bitmap of destinations held in the load buffer
- rf_we_o  out  1  RF write enable
- rf_waddr_o  out  5  RF write address
- rf_wdata_o  out  32  RF write data
- rf_src_o  out  2  source of the current write: 0 wb, 1 lsu (live or buffered), 2 aux, 3 none

## Operation
State:
- 2-entry in-order load FIFO (waddr and wdata) with count 0..2.
- Starvation counter, saturating at StarveLimit.
- `starve = (counter == StarveLimit)`.
- `stall_o = (count != 0) | starve`, purely from registered state.

Contract: `wb_we_i` is 0 whenever `stall_o` is 1. Enforce this with an assertion; it is not handled by the block.

Per-cycle grant, first matching rule wins:
1. `wb_we_i`: write wb. A live load pushes to the FIFO. Aux is not granted.
2. `starve` and count ≤ 1: write aux (`aux_ready_o` = 1). A live load pushes.
3. count > 0: write the FIFO head and pop. A live load pushes in the same cycle.
4. `lsu_we_i`: write the live load directly; no FIFO activity.
5. `aux_valid_i`: write aux.
6. None of the above: `rf_we_o` = 0, `rf_src_o` = 3.

Load ordering:
- Loads always retire in arrival order.
- A live load never bypasses a non-empty FIFO.

Overflow:
- Count never exceeds 2.
- Push when full is illegal. Flag it with an assertion; it is unreachable under the contract.

Starvation counter:
- Increments when `aux_valid_i` & ~`aux_ready_o`.
- Clears when `aux_ready_o` = 1 or `aux_valid_i` = 0.
- Holds at StarveLimit.

`rf_wr_pending_o`:
- OR of one-hot(waddr) over valid FIFO entries, including address 0.
- ID uses it as an extra read hazard.

Writes to x0 pass through unchanged; the RF discards them.

Ordering between aux writes and loads to the same register is the requesters' responsibility.

## Timing
- Outputs `rf_*`, `aux_ready_o` and `rf_src_o` are combinational from inputs and state, with zero-cycle latency for direct writes.
- A buffered load writes one or more cycles after arrival. The minimum is the next cycle.
- `stall_o` and `rf_wr_pending_o` are registered-state only, with no input-to-output path.

Reset (`rst_i` high, asynchronous):
- FIFO count 0, starvation counter 0.
- `stall_o` 0, `rf_wr_pending_o` 0.
- With idle inputs: `rf_we_o` 0, `aux_ready_o` 0, `rf_src_o` 3.
- Reset mid-operation discards buffered loads.

Boundary cases:
- **Collision with empty FIFO:** wb and lsu in the same cycle → count 0→1, and `stall_o` rises next cycle.
- **Count 1, streaming loads:** pop plus push, count stays 1.
- **Count 2 with starve:** rule 2 is blocked. Aux waits until count ≤ 1.
- **Forced aux grant with count 1 and a live load:** count 1→2.
- **Aux under starve with no loads:** aux is granted in the first cycle `starve` = 1. The counter returns to 0 the next cycle.

## Test plan
- **Reset/idle:** assert `rst_i` mid-burst with FIFO count 2 → the next cycle shows count 0, `stall_o` 0, `rf_wr_pending_o` 0, `rf_we_o` 0.
- **Collision:**
  - Stimulus: wb (x5, 0x11) and lsu (x6, 0x22) in the same cycle.
  - Same cycle: `rf_waddr_o` = 5, `rf_src_o` = 0.
  - Next cycle: `stall_o` = 1, `rf_wr_pending_o` = 0x40, and the RF writes x6 = 0x22 with `rf_src_o` = 1.
  - Following cycle: `stall_o` = 0.
- **Load ordering:**
  - Stimulus: collision, then lsu (x6, 0x33) in the following cycle.
  - RF writes x6 = 0x22, then x6 = 0x33 in consecutive cycles.
  - The final value of x6 is 0x33.
- **Aux starvation:**
  - Stimulus: hold `aux_valid_i` with StarveLimit = 4 while wb writes every cycle.
  - `stall_o` rises after 4 un-granted cycles.
  - In that cycle `aux_ready_o` = 1 and `rf_src_o` = 2.
  - The counter reads 0 the next cycle.
- **Starve blocked by full FIFO:**
  - Stimulus: count 2 with loads streaming and starve = 1.
  - Aux is not granted while count = 2.
  - Aux is granted the first cycle count ≤ 1, and count never exceeds 2.
- **Idle aux:** `aux_valid_i` with no other traffic → `aux_ready_o` = 1 in the same cycle, `rf_src_o` = 2, and the counter stays 0.
